// File: rtl/ex_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_forward_hazard_unit
// Purpose  : Operand-forwarding and load-use hazard controller for the
//            5-stage pipeline. A two-entry scoreboard mirrors the destination
//            registers of the instructions now in EX (entry E) and MEM
//            (entry M). From it the unit produces the forward selects for the
//            instruction leaving ID and the load-use Stall. It also keeps a
//            saturating count of stall events.
// Ports    :
//   Clock        in   pipeline clock
//   Reset        in   asynchronous, active-low reset
//   ClockEnable  in   global clock enable
//   Tick         in   pipeline advance strobe (Advance = ClockEnable & Tick)
//   Flush        in   taken branch/jump resolved in EX: kill ID and EX
//   IdValid      in   ID holds a real instruction
//   IdRs1/IdRs2  in   ID source register indices
//   IdRs1Used    in   instruction reads rs1
//   IdRs2Used    in   instruction reads rs2
//   IdRd         in   ID destination register index
//   IdRegWrite   in   instruction writes rd
//   IdMemRead    in   instruction is a load
//   Rs1ForwardD  out  next EX rs1 select (0 regfile, 1 EX/MEM, 2 MEM/WB)
//   Rs2ForwardD  out  next EX rs2 select, same encoding
//   Stall        out  hold PC and IF/ID, insert a bubble into EX
//   StallCount   out  saturating count of stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module ex_forward_hazard_unit #(
    parameter int NrOfRegBits = 5,
    parameter int CountBits   = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   ClockEnable,
    input  logic                   Tick,
    input  logic                   Flush,
    input  logic                   IdValid,
    input  logic [NrOfRegBits-1:0] IdRs1,
    input  logic [NrOfRegBits-1:0] IdRs2,
    input  logic                   IdRs1Used,
    input  logic                   IdRs2Used,
    input  logic [NrOfRegBits-1:0] IdRd,
    input  logic                   IdRegWrite,
    input  logic                   IdMemRead,
    output logic [1:0]             Rs1ForwardD,
    output logic [1:0]             Rs2ForwardD,
    output logic                   Stall,
    output logic [CountBits-1:0]   StallCount
);

    localparam logic [1:0] c_fwd_regfile = 2'd0;
    localparam logic [1:0] c_fwd_exmem   = 2'd1;
    localparam logic [1:0] c_fwd_memwb   = 2'd2;

    localparam logic [NrOfRegBits-1:0] c_reg_zero  = '0;
    localparam logic [CountBits-1:0]   c_count_max = '1;
    localparam logic [CountBits-1:0]   c_count_one = {{(CountBits-1){1'b0}}, 1'b1};

    // Scoreboard entry E: instruction currently in EX
    logic                   r_e_valid;
    logic [NrOfRegBits-1:0] r_e_rd;
    logic                   r_e_we;
    logic                   r_e_load;

    // Scoreboard entry M: instruction currently in MEM
    logic                   r_m_valid;
    logic [NrOfRegBits-1:0] r_m_rd;
    logic                   r_m_we;
    logic                   r_m_load;

    logic [CountBits-1:0]   r_stall_count;

    logic w_advance;
    logic w_e_writes;
    logic w_m_writes;
    logic w_e_hit_rs1;
    logic w_e_hit_rs2;
    logic w_m_hit_rs1;
    logic w_m_hit_rs2;
    logic w_stall;
    logic w_bubble;
    logic w_fwd_allowed;

    assign w_advance = ClockEnable & Tick;

    // An entry can only supply data if it is a real instruction that writes a
    // register other than x0 (x0 is hard-wired zero and never forwarded).
    assign w_e_writes = r_e_valid & r_e_we & (r_e_rd != c_reg_zero);
    assign w_m_writes = r_m_valid & r_m_we & (r_m_rd != c_reg_zero);

    assign w_e_hit_rs1 = w_e_writes & (r_e_rd == IdRs1);
    assign w_e_hit_rs2 = w_e_writes & (r_e_rd == IdRs2);
    assign w_m_hit_rs1 = w_m_writes & (r_m_rd == IdRs1);
    assign w_m_hit_rs2 = w_m_writes & (r_m_rd == IdRs2);

    // A load in EX has no data yet, so a dependent instruction in ID must wait
    // one advance; Flush kills the ID instruction so there is nothing to hold.
    assign w_stall = IdValid & ~Flush & r_e_load &
                     ((IdRs1Used & w_e_hit_rs1) | (IdRs2Used & w_e_hit_rs2));

    assign Stall = w_stall;

    // E receives a bubble whenever the ID instruction does not move into EX.
    assign w_bubble = w_stall | Flush | ~IdValid;

    assign w_fwd_allowed = IdValid & ~Flush & ~w_stall;

    // Nearer stage wins: an E match is checked before an M match. A load in E
    // never forwards from EX/MEM (its data is not there yet).
    always_comb begin
        Rs1ForwardD = c_fwd_regfile;
        if (w_fwd_allowed && IdRs1Used) begin
            if (w_e_hit_rs1 && !r_e_load) begin
                Rs1ForwardD = c_fwd_exmem;
            end else if (w_m_hit_rs1) begin
                Rs1ForwardD = c_fwd_memwb;
            end
        end
    end

    always_comb begin
        Rs2ForwardD = c_fwd_regfile;
        if (w_fwd_allowed && IdRs2Used) begin
            if (w_e_hit_rs2 && !r_e_load) begin
                Rs2ForwardD = c_fwd_exmem;
            end else if (w_m_hit_rs2) begin
                Rs2ForwardD = c_fwd_memwb;
            end
        end
    end

    // Scoreboard shift: E -> M, ID (or a bubble) -> E, only on Advance.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_e_valid <= 1'b0;
            r_e_rd    <= c_reg_zero;
            r_e_we    <= 1'b0;
            r_e_load  <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_rd    <= c_reg_zero;
            r_m_we    <= 1'b0;
            r_m_load  <= 1'b0;
        end else if (w_advance) begin
            r_m_valid <= r_e_valid;
            r_m_rd    <= r_e_rd;
            r_m_we    <= r_e_we;
            r_m_load  <= r_e_load;
            if (w_bubble) begin
                r_e_valid <= 1'b0;
                r_e_rd    <= c_reg_zero;
                r_e_we    <= 1'b0;
                r_e_load  <= 1'b0;
            end else begin
                r_e_valid <= 1'b1;
                r_e_rd    <= IdRd;
                r_e_we    <= IdRegWrite;
                r_e_load  <= IdMemRead;
            end
        end
    end

    // Counted only on the advancing edge, so a stall held across Tick=0
    // cycles is recorded once. Saturates instead of wrapping.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_stall_count <= '0;
        end else if (w_advance && w_stall && (r_stall_count != c_count_max)) begin
            r_stall_count <= r_stall_count + c_count_one;
        end
    end

    assign StallCount = r_stall_count;

    // The M-entry load flag only matters once the entry moves on; it is kept
    // so the scoreboard entry stays complete.
    logic w_unused;
    assign w_unused = r_m_load;

endmodule

`default_nettype wire

// File: tb/tb_ex_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_forward_hazard_unit
// Purpose  : Self-checking bench for ex_forward_hazard_unit. A second instance
//            with a 4-bit stall counter exposes counter saturation quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_forward_hazard_unit;

    logic       Clock       = 1'b0;
    logic       Reset       = 1'b0;
    logic       ClockEnable = 1'b0;
    logic       Tick        = 1'b0;
    logic       Flush       = 1'b0;
    logic       IdValid     = 1'b0;
    logic [4:0] IdRs1       = 5'd0;
    logic [4:0] IdRs2       = 5'd0;
    logic       IdRs1Used   = 1'b0;
    logic       IdRs2Used   = 1'b0;
    logic [4:0] IdRd        = 5'd0;
    logic       IdRegWrite  = 1'b0;
    logic       IdMemRead   = 1'b0;

    logic [1:0]  Rs1ForwardD, Rs2ForwardD;
    logic        Stall;
    logic [15:0] StallCount;
    logic [1:0]  Rs1ForwardD_s, Rs2ForwardD_s;
    logic        Stall_s;
    logic [3:0]  StallCount_s;

    always #5 Clock = ~Clock;

    ex_forward_hazard_unit #(.NrOfRegBits(5), .CountBits(16)) u_dut (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .Flush(Flush), .IdValid(IdValid), .IdRs1(IdRs1), .IdRs2(IdRs2),
        .IdRs1Used(IdRs1Used), .IdRs2Used(IdRs2Used), .IdRd(IdRd),
        .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
        .Rs1ForwardD(Rs1ForwardD), .Rs2ForwardD(Rs2ForwardD),
        .Stall(Stall), .StallCount(StallCount)
    );

    ex_forward_hazard_unit #(.NrOfRegBits(5), .CountBits(4)) u_sat (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .Flush(Flush), .IdValid(IdValid), .IdRs1(IdRs1), .IdRs2(IdRs2),
        .IdRs1Used(IdRs1Used), .IdRs2Used(IdRs2Used), .IdRd(IdRd),
        .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
        .Rs1ForwardD(Rs1ForwardD_s), .Rs2ForwardD(Rs2ForwardD_s),
        .Stall(Stall_s), .StallCount(StallCount_s)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: stg[0] is the instruction in EX, stg[1] the one in
    // MEM. Outputs are derived directly from the hazard/forwarding rules.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ent_t;

    ent_t stg [2];
    int   mCount  = 0;
    int   mCountS = 0;

    function automatic bit hit(input ent_t e, input logic [4:0] rs);
        return e.v && e.we && (e.rd != 5'd0) && (e.rd == rs);
    endfunction

    function automatic bit exp_stall();
        return IdValid && !Flush && stg[0].ld &&
               ((IdRs1Used && hit(stg[0], IdRs1)) || (IdRs2Used && hit(stg[0], IdRs2)));
    endfunction

    function automatic logic [1:0] exp_sel(input logic [4:0] rs, input logic used);
        if (exp_stall() || Flush || !IdValid || !used) return 2'd0;
        if (hit(stg[0], rs) && !stg[0].ld) return 2'd1;
        if (hit(stg[1], rs)) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stg[0]  <= '0;
            stg[1]  <= '0;
            mCount  <= 0;
            mCountS <= 0;
        end else if (ClockEnable && Tick) begin
            if (exp_stall()) begin
                if (mCount < 65535) mCount <= mCount + 1;
                if (mCountS < 15)   mCountS <= mCountS + 1;
            end
            stg[1] <= stg[0];
            if (exp_stall() || Flush || !IdValid) stg[0] <= '0;
            else stg[0] <= ent_t'{1'b1, IdRd, IdRegWrite, IdMemRead};
        end
    end

    // Compare process: every falling edge, both instances against the model.
    always @(negedge Clock) begin
        check("stall",     {31'd0, Stall},          {31'd0, exp_stall()});
        check("rs1_sel",   {30'd0, Rs1ForwardD},    {30'd0, exp_sel(IdRs1, IdRs1Used)});
        check("rs2_sel",   {30'd0, Rs2ForwardD},    {30'd0, exp_sel(IdRs2, IdRs2Used)});
        check("count",     {16'd0, StallCount},     mCount);
        check("stall_s",   {31'd0, Stall_s},        {31'd0, exp_stall()});
        check("rs1_sel_s", {30'd0, Rs1ForwardD_s},  {30'd0, exp_sel(IdRs1, IdRs1Used)});
        check("rs2_sel_s", {30'd0, Rs2ForwardD_s},  {30'd0, exp_sel(IdRs2, IdRs2Used)});
        check("count_s",   {28'd0, StallCount_s},   mCountS);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [4:0] reg_pool [4] = '{5'd0, 5'd5, 5'd8, 5'd13};

    function automatic logic [4:0] pick();
        return reg_pool[$urandom_range(0, 3)];
    endfunction

    task automatic nxt();
        @(posedge Clock);
        #1;
    endtask

    task automatic id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic we, input logic ld);
        IdValid = v; IdRs1 = r1; IdRs2 = r2; IdRs1Used = u1; IdRs2Used = u2;
        IdRd = rd; IdRegWrite = we; IdMemRead = ld;
    endtask

    task automatic drive_random();
        ClockEnable = ($urandom_range(0, 7) != 0);
        Tick        = ($urandom_range(0, 3) != 0);
        Flush       = ($urandom_range(0, 9) == 0);
        id(($urandom_range(0, 7) != 0), pick(), pick(),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), pick(),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    endtask

    task automatic expect_out(input string tag, input logic [1:0] s1, input logic [1:0] s2,
                              input logic st, input int cnt);
        check({tag, ".rs1"},   {30'd0, Rs1ForwardD}, {30'd0, s1});
        check({tag, ".rs2"},   {30'd0, Rs2ForwardD}, {30'd0, s2});
        check({tag, ".stall"}, {31'd0, Stall},       {31'd0, st});
        check({tag, ".count"}, {16'd0, StallCount},  cnt);
    endtask

    initial begin
        // Reset held with arbitrary inputs
        drive_random();
        repeat (3) begin nxt(); drive_random(); end
        @(negedge Clock);
        expect_out("reset", 2'd0, 2'd0, 1'b0, 0);

        // Release with no advance: still quiet
        nxt();
        Reset = 1'b1; ClockEnable = 1'b1; Tick = 1'b0; Flush = 1'b0;
        id(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1);
        @(negedge Clock);
        expect_out("post_reset", 2'd0, 2'd0, 1'b0, 0);

        // ADD x5 ; SUB x6,x5,x7 -> rs1 from EX/MEM
        nxt(); Tick = 1'b1; id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        nxt(); id(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0);
        @(negedge Clock);
        expect_out("ex_fwd", 2'd1, 2'd0, 1'b0, 0);

        // ADD x5 ; unrelated ; consumer x5 in rs2 -> MEM/WB
        nxt(); id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        nxt(); id(1, 5'd1, 5'd2, 1, 1, 5'd11, 1, 0);
        nxt(); id(1, 5'd3, 5'd5, 1, 1, 5'd10, 1, 0);
        @(negedge Clock);
        expect_out("mem_fwd", 2'd0, 2'd2, 1'b0, 0);

        // Both E and M write x5 -> E wins
        nxt(); id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        nxt(); id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        nxt(); id(1, 5'd5, 5'd3, 1, 1, 5'd14, 1, 0);
        @(negedge Clock);
        expect_out("prio", 2'd1, 2'd0, 1'b0, 0);

        // LW x8 ; consumer rs1=x8 -> stall, held through Tick=0, counted once
        nxt(); id(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1);
        nxt(); id(1, 5'd8, 5'd3, 1, 1, 5'd15, 1, 0);
        @(negedge Clock);
        expect_out("load_use", 2'd0, 2'd0, 1'b1, 0);
        Tick = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            expect_out("hold", 2'd0, 2'd0, 1'b1, 0);
        end
        Tick = 1'b1;
        @(negedge Clock);
        expect_out("after_stall", 2'd2, 2'd0, 1'b0, 1);

        // x0 producers never forward or stall
        nxt(); id(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1);
        nxt(); id(1, 5'd0, 5'd0, 1, 1, 5'd16, 1, 0);
        @(negedge Clock);
        expect_out("x0_load", 2'd0, 2'd0, 1'b0, 1);
        nxt(); id(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
        nxt(); id(1, 5'd0, 5'd0, 1, 1, 5'd17, 1, 0);
        @(negedge Clock);
        expect_out("x0_alu", 2'd0, 2'd0, 1'b0, 1);

        // Flush during load-use: no stall, flushed rd not forwarded later
        nxt(); id(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1);
        nxt(); id(1, 5'd8, 5'd8, 1, 1, 5'd12, 1, 0); Flush = 1'b1;
        @(negedge Clock);
        expect_out("flush", 2'd0, 2'd0, 1'b0, 1);
        nxt(); Flush = 1'b0; id(1, 5'd12, 5'd12, 1, 1, 5'd18, 1, 0);
        @(negedge Clock);
        expect_out("flushed_rd", 2'd0, 2'd0, 1'b0, 1);

        // 2^4+3 stalls: small counter saturates, wide one keeps counting
        for (int i = 0; i < 19; i++) begin
            nxt(); id(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1);
            nxt(); id(1, 5'd8, 5'd0, 1, 0, 5'd19, 1, 0);
        end
        nxt(); id(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
        @(negedge Clock);
        check("sat_small", {28'd0, StallCount_s}, 32'd15);
        check("sat_wide",  {16'd0, StallCount},   32'd20);

        // Mid-stall reset: state cleared immediately
        nxt(); id(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1);
        nxt(); id(1, 5'd8, 5'd8, 1, 1, 5'd20, 1, 0);
        @(negedge Clock);
        check("pre_reset_stall", {31'd0, Stall}, 32'd1);
        Reset = 1'b0;
        #1;
        check("async_reset_stall", {31'd0, Stall}, 32'd0);
        check("async_reset_count", {16'd0, StallCount}, 32'd0);
        nxt(); Reset = 1'b1;
        @(negedge Clock);
        expect_out("first_post_reset", 2'd0, 2'd0, 1'b0, 0);

        // Randomized phase with occasional resets
        for (int i = 0; i < 4000; i++) begin
            nxt();
            if ($urandom_range(0, 299) == 0) Reset = 1'b0;
            else Reset = 1'b1;
            drive_random();
        end
        nxt();
        Reset = 1'b1;
        @(negedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
